// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            requesters. Optional WAIT_DONE watchdog: UART_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NEWD_HOLD = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   cmpl,
    output logic                 busy,
    output logic                 newd,
    output logic [7:0]           dintx,
    input  logic                 donetx,
    output logic                 err_timeout
);

    localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_HW = $clog2(NEWD_HOLD + 1);
    localparam logic [NUM_REQ-1:0] c_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_PW-1:0]    c_LAST = c_PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [c_PW-1:0]      r_ptr,      w_ptr_nxt;
    logic [c_PW-1:0]      r_owner,    w_owner_nxt;
    logic [c_HW-1:0]      r_hold_cnt, w_hold_nxt;
    logic                 r_donetx_q;
    logic [NUM_REQ-1:0]   r_gnt,      w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_cmpl,     w_cmpl_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_newd,     w_newd_nxt;
    logic [7:0]           r_dintx,    w_dintx_nxt;
    logic                 r_err,      w_err_nxt;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [c_TW-1:0]      r_to_cnt,   w_to_nxt;
`endif

    logic                 w_found;
    logic [c_PW-1:0]      w_winner;
    logic [7:0]           w_win_byte;
    logic                 w_rise;

    assign w_rise = donetx & ~r_donetx_q;

    // First requesting index at or above ptr, wrapping past NUM_REQ-1 to 0.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found    = 1'b1;
                w_winner   = c_PW'(idx);
                w_win_byte = req_data[8*idx +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = '0;
        w_cmpl_nxt  = '0;
        w_busy_nxt  = r_busy;
        w_newd_nxt  = r_newd;
        w_dintx_nxt = r_dintx;
        w_err_nxt   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_nxt    = r_to_cnt;
`endif
        case (r_state)
            IDLE: begin
                w_newd_nxt = 1'b0;
                if (w_found) begin
                    w_gnt_nxt   = c_ONE << w_winner;
                    w_busy_nxt  = 1'b1;
                    w_newd_nxt  = 1'b1;
                    w_dintx_nxt = w_win_byte;
                    w_owner_nxt = w_winner;
                    w_ptr_nxt   = (w_winner == c_LAST) ? '0 : c_PW'(w_winner + 1'b1);
                    // The grant cycle itself is the first newd-high cycle.
                    w_hold_nxt  = c_HW'(1);
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_hold_cnt == c_HW'(NEWD_HOLD)) begin
                    w_newd_nxt  = 1'b0;
                    w_hold_nxt  = '0;
                    w_state_nxt = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    w_to_nxt    = '0;
`endif
                end else begin
                    w_hold_nxt = c_HW'(r_hold_cnt + 1'b1);
                end
            end
            WAIT_DONE: begin
                // A rise coinciding with the watchdog limit wins as completion.
                if (w_rise) begin
                    w_cmpl_nxt  = c_ONE << r_owner;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (r_to_cnt == c_TW'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_nxt = c_TW'(r_to_cnt + 1'b1);
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_newd_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_donetx_q <= 1'b0;
            r_gnt      <= '0;
            r_cmpl     <= '0;
            r_busy     <= 1'b0;
            r_newd     <= 1'b0;
            r_dintx    <= 8'h00;
            r_err      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_donetx_q <= donetx;
            r_gnt      <= w_gnt_nxt;
            r_cmpl     <= w_cmpl_nxt;
            r_busy     <= w_busy_nxt;
            r_newd     <= w_newd_nxt;
            r_dintx    <= w_dintx_nxt;
            r_err      <= w_err_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt   <= w_to_nxt;
`endif
        end
    end

    assign gnt         = r_gnt;
    assign cmpl        = r_cmpl;
    assign busy        = r_busy;
    assign newd        = r_newd;
    assign dintx       = r_dintx;
    assign err_timeout = r_err;

endmodule

`default_nettype wire
